control_unit: RTL and testbench

Hardwired Moore control sequencer for the Mini SRC datapath. It replaces the hand-driven state sequences used in the per-instruction datapath benches. Each cycle it steps a T-state counter through instruction fetch and then through the execute microsequence selected by the IR opcode. It drives every bus-driver select, register load, memory strobe and ALU opcode into `Datapath`.

---
 rtl/ctrl_pkg.sv | 23 ++
 rtl/control_unit_if.sv | 21 ++
 rtl/ctrl_op_class.sv | 36 +++
 rtl/control_unit.sv | 186 ++++++++++++++++++
 tb/tb_control_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, state encoding, bus-driver/load bit map, ALU opcodes and instruction classes for control_unit
package ctrl_pkg;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4,
                         OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7, OP_SHRA = 5'd8, OP_SHL = 5'd9,
                         OP_ROR = 5'd10, OP_ROL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14,
                         OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19,
                         OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24,
                         OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_e;
  // drv is 11 bits wide; bit 10 is reserved and never driven
  localparam int DRV_W = 11;
  localparam int D_PC = 0, D_ZLO = 1, D_ZHI = 2, D_HI = 3, D_LO = 4, D_MDR = 5, D_C = 6, D_INP = 7,
                 D_R = 8, D_BA = 9;
  // eleven load strobes, one per register listed for the datapath
  localparam int LD_W = 11;
  localparam int L_MAR = 0, L_MDR = 1, L_PC = 2, L_IR = 3, L_Y = 4, L_Z = 5, L_HI = 6, L_LO = 7,
                 L_R = 8, L_OUTP = 9, L_CON = 10;
  // gsel = {Gra, Grb, Grc}
  localparam int G_A = 2, G_B = 1, G_C = 0;
  localparam logic [4:0] ALU_ADD = OP_ADD, ALU_AND = OP_AND, ALU_OR = OP_OR;
  typedef enum logic [4:0] {C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL,
                            C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL} op_class_e;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: sequencer <-> datapath bundle
//   master (control_unit): in ir_op, con; out alu_op, drv, ld, gsel, Read, RAM_write_enable, IncPC, run, illegal
//   slave  (datapath): the mirror image
interface control_unit_if;
  import ctrl_pkg::*;
  logic [4:0] ir_op;
  logic con;
  logic [4:0] alu_op;
  logic [DRV_W-1:0] drv;
  logic [LD_W-1:0] ld;
  logic [2:0] gsel;
  logic Read;
  logic RAM_write_enable;
  logic IncPC;
  logic run;
  logic illegal;
  modport master (input ir_op, con,
                  output alu_op, drv, ld, gsel, Read, RAM_write_enable, IncPC, run, illegal);
  modport slave (output ir_op, con,
                 input alu_op, drv, ld, gsel, Read, RAM_write_enable, IncPC, run, illegal);
endinterface

// File: rtl/ctrl_op_class.sv
// ctrl_op_class: combinational opcode -> instruction class map
//   in ir_op (5); out op_class
//   CTRL_MULDIV_EN: when undefined, mul/div decode as illegal
module ctrl_op_class
  import ctrl_pkg::*;
(
  input  logic [4:0] ir_op,
  output op_class_e  op_class
);
  always_comb begin
    op_class = C_ILL;
    case (ir_op) inside
      OP_LD: op_class = C_LD;
      OP_LDI: op_class = C_LDI;
      OP_ST: op_class = C_ST;
      [OP_ADD:OP_ROL]: op_class = C_RTYPE;
      [OP_ADDI:OP_ORI]: op_class = C_IMM;
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV: op_class = C_MULDIV;
`else
      OP_MUL, OP_DIV: op_class = C_ILL;
`endif
      OP_NEG, OP_NOT: op_class = C_UNARY;
      OP_BR: op_class = C_BR;
      OP_JR: op_class = C_JR;
      OP_JAL: op_class = C_JAL;
      OP_IN: op_class = C_IN;
      OP_OUT: op_class = C_OUT;
      OP_MFHI: op_class = C_MFHI;
      OP_MFLO: op_class = C_MFLO;
      OP_NOP: op_class = C_NOP;
      OP_HALT: op_class = C_HALT;
      default: op_class = C_ILL;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore T-state sequencer for the Mini SRC datapath
//   clk: rising-edge clock; clr: asynchronous active-low reset
//   bus (control_unit_if.master): ir_op/con in; alu_op, drv, ld, gsel, strobes, run, illegal out
//   CTRL_MULDIV_EN: enables mul/div microcode (see ctrl_op_class)
module control_unit
  import ctrl_pkg::*;
(
  input logic clk,
  input logic clr,
  control_unit_if.master bus
);
  state_e state_q, state_d;
  op_class_e cls;
  ctrl_op_class u_class (.ir_op(bus.ir_op), .op_class(cls));
  always_ff @(posedge clk or negedge clr)
    if (!clr) state_q <= S_RST;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = cls == C_NOP ? S_T0 : S_T3;
      S_T3: state_d = cls == C_HALT ? S_HALT :
                      cls inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_ILL} ? S_T0 : S_T4;
      S_T4: state_d = cls inside {C_UNARY, C_JAL} ? S_T0 : S_T5;
      S_T5: state_d = cls inside {C_RTYPE, C_IMM, C_LDI} ? S_T0 : S_T6;
      S_T6: state_d = cls inside {C_LD, C_ST} ? S_T7 : S_T0;
      S_T7: state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end
  always_comb begin
    bus.alu_op = '0;
    bus.drv = '0;
    bus.ld = '0;
    bus.gsel = '0;
    bus.Read = 1'b0;
    bus.RAM_write_enable = 1'b0;
    bus.IncPC = 1'b0;
    bus.illegal = 1'b0;
    bus.run = !(state_q inside {S_RST, S_HALT});
    case (state_q)
      S_T0: begin
        bus.drv[D_PC] = 1'b1;
        bus.ld[L_MAR] = 1'b1;
        bus.ld[L_Z] = 1'b1;
        bus.IncPC = 1'b1;
      end
      S_T1: begin
        bus.drv[D_ZLO] = 1'b1;
        bus.ld[L_PC] = 1'b1;
        bus.ld[L_MDR] = 1'b1;
        bus.Read = 1'b1;
      end
      S_T2: begin
        bus.drv[D_MDR] = 1'b1;
        bus.ld[L_IR] = 1'b1;
      end
      S_T3: case (cls)
        C_RTYPE, C_IMM: begin
          bus.gsel[G_B] = 1'b1;
          bus.drv[D_R] = 1'b1;
          bus.ld[L_Y] = 1'b1;
        end
        C_UNARY: begin
          bus.gsel[G_B] = 1'b1;
          bus.drv[D_R] = 1'b1;
          bus.alu_op = bus.ir_op;
          bus.ld[L_Z] = 1'b1;
        end
        C_MULDIV: begin
          bus.gsel[G_A] = 1'b1;
          bus.drv[D_R] = 1'b1;
          bus.ld[L_Y] = 1'b1;
        end
        C_LD, C_LDI, C_ST: begin
          bus.gsel[G_B] = 1'b1;
          bus.drv[D_BA] = 1'b1;
          bus.ld[L_Y] = 1'b1;
        end
        C_BR, C_JR, C_OUT: begin
          bus.gsel[G_A] = 1'b1;
          bus.drv[D_R] = 1'b1;
          bus.ld[L_CON] = cls == C_BR;
          bus.ld[L_PC] = cls == C_JR;
          bus.ld[L_OUTP] = cls == C_OUT;
        end
        C_JAL: begin
          bus.drv[D_PC] = 1'b1;
          bus.gsel[G_B] = 1'b1;
          bus.ld[L_R] = 1'b1;
        end
        C_IN, C_MFHI, C_MFLO: begin
          bus.drv[D_INP] = cls == C_IN;
          bus.drv[D_HI] = cls == C_MFHI;
          bus.drv[D_LO] = cls == C_MFLO;
          bus.gsel[G_A] = 1'b1;
          bus.ld[L_R] = 1'b1;
        end
        C_ILL: bus.illegal = 1'b1;
        default: ;
      endcase
      S_T4: case (cls)
        C_RTYPE, C_MULDIV: begin
          bus.gsel[G_C] = cls == C_RTYPE;
          bus.gsel[G_B] = cls == C_MULDIV;
          bus.drv[D_R] = 1'b1;
          bus.alu_op = bus.ir_op;
          bus.ld[L_Z] = 1'b1;
        end
        C_IMM, C_LD, C_LDI, C_ST: begin
          bus.drv[D_C] = 1'b1;
          bus.alu_op = cls != C_IMM || bus.ir_op == OP_ADDI ? ALU_ADD :
                       bus.ir_op == OP_ANDI ? ALU_AND : ALU_OR;
          bus.ld[L_Z] = 1'b1;
        end
        C_UNARY: begin
          bus.drv[D_ZLO] = 1'b1;
          bus.gsel[G_A] = 1'b1;
          bus.ld[L_R] = 1'b1;
        end
        C_BR: begin
          bus.drv[D_PC] = 1'b1;
          bus.ld[L_Y] = 1'b1;
        end
        C_JAL: begin
          bus.gsel[G_A] = 1'b1;
          bus.drv[D_R] = 1'b1;
          bus.ld[L_PC] = 1'b1;
        end
        default: ;
      endcase
      S_T5: case (cls)
        C_RTYPE, C_IMM, C_LDI: begin
          bus.drv[D_ZLO] = 1'b1;
          bus.gsel[G_A] = 1'b1;
          bus.ld[L_R] = 1'b1;
        end
        C_MULDIV, C_LD, C_ST: begin
          bus.drv[D_ZLO] = 1'b1;
          bus.ld[L_LO] = cls == C_MULDIV;
          bus.ld[L_MAR] = cls != C_MULDIV;
        end
        C_BR: begin
          bus.drv[D_C] = 1'b1;
          bus.alu_op = ALU_ADD;
          bus.ld[L_Z] = 1'b1;
        end
        default: ;
      endcase
      S_T6: case (cls)
        C_MULDIV: begin
          bus.drv[D_ZHI] = 1'b1;
          bus.ld[L_HI] = 1'b1;
        end
        C_LD: begin
          bus.Read = 1'b1;
          bus.ld[L_MDR] = 1'b1;
        end
        C_ST: begin
          bus.gsel[G_A] = 1'b1;
          bus.drv[D_R] = 1'b1;
          bus.ld[L_MDR] = 1'b1;
        end
        C_BR: begin
          bus.drv[D_ZLO] = 1'b1;
          bus.ld[L_PC] = bus.con;
        end
        default: ;
      endcase
      S_T7: case (cls)
        C_LD: begin
          bus.drv[D_MDR] = 1'b1;
          bus.gsel[G_A] = 1'b1;
          bus.ld[L_R] = 1'b1;
        end
        C_ST: bus.RAM_write_enable = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-instruction microstep model vs control_unit, directed plan then random opcodes with random aborts
module tb_control_unit;
  import ctrl_pkg::*;
  typedef struct packed {
    logic [4:0] alu;
    logic [10:0] drv;
    logic [10:0] ld;
    logic [2:0] g;
    logic rd, we, inc, run, ill;
  } out_t;
`ifdef CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr;
  control_unit_if bus();
  control_unit dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  out_t exp_o = '0;
  bit exp_v = 1'b0;
  bit dir = 1'b1;
  int cur_op = -1, cur_k = -1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  function automatic out_t dut_out();
    return {bus.alu_op, bus.drv, bus.ld, bus.gsel, bus.Read, bus.RAM_write_enable, bus.IncPC, bus.run, bus.illegal};
  endfunction
  function automatic bit is_ill(int op);
    return op >= 28 || (!MD && (op == 15 || op == 16));
  endfunction
  function automatic int ilen(int op);
    if (op == 26) return 3;
    if (is_ill(op) || op == 20 || op == 22 || op == 23 || op == 24 || op == 25 || op == 27) return 4;
    if (op == 17 || op == 18 || op == 21) return 5;
    if ((op >= 3 && op <= 14) || op == 1) return 6;
    if (op == 15 || op == 16 || op == 19) return 7;
    return 8;
  endfunction
  function automatic out_t mv(out_t o, int d, int l, int g);
    if (d >= 0) o.drv[d] = 1'b1;
    if (l >= 0) o.ld[l] = 1'b1;
    if (g >= 0) o.g[g] = 1'b1;
    return o;
  endfunction
  // expected outputs on cycle k (0 = T0) of instruction op
  function automatic out_t model(int op, int k, logic c);
    out_t o = '0;
    bit rt = op >= 3 && op <= 11;
    bit im = op >= 12 && op <= 14;
    o.run = 1'b1;
    if (k == 0) begin o = mv(o, D_PC, L_MAR, -1); o.ld[L_Z] = 1'b1; o.inc = 1'b1; return o; end
    if (k == 1) begin o = mv(o, D_ZLO, L_PC, -1); o.ld[L_MDR] = 1'b1; o.rd = 1'b1; return o; end
    if (k == 2) return mv(o, D_MDR, L_IR, -1);
    if (is_ill(op)) begin o.ill = 1'b1; return o; end
    if (rt || im) begin
      if (k == 3) o = mv(o, D_R, L_Y, G_B);
      if (k == 4) begin
        o = rt ? mv(o, D_R, L_Z, G_C) : mv(o, D_C, L_Z, -1);
        o.alu = rt ? 5'(op) : op == 12 ? 5'd3 : op == 13 ? 5'd5 : 5'd6;
      end
      if (k == 5) o = mv(o, D_ZLO, L_R, G_A);
    end
    if (op == 17 || op == 18) begin
      if (k == 3) begin o = mv(o, D_R, L_Z, G_B); o.alu = 5'(op); end
      if (k == 4) o = mv(o, D_ZLO, L_R, G_A);
    end
    if (op == 15 || op == 16) begin
      if (k == 3) o = mv(o, D_R, L_Y, G_A);
      if (k == 4) begin o = mv(o, D_R, L_Z, G_B); o.alu = 5'(op); end
      if (k == 5) o = mv(o, D_ZLO, L_LO, -1);
      if (k == 6) o = mv(o, D_ZHI, L_HI, -1);
    end
    if (op <= 2) begin
      if (k == 3) o = mv(o, D_BA, L_Y, G_B);
      if (k == 4) begin o = mv(o, D_C, L_Z, -1); o.alu = 5'd3; end
      if (k == 5) o = op == 1 ? mv(o, D_ZLO, L_R, G_A) : mv(o, D_ZLO, L_MAR, -1);
      if (k == 6 && op == 0) begin o = mv(o, -1, L_MDR, -1); o.rd = 1'b1; end
      if (k == 6 && op == 2) o = mv(o, D_R, L_MDR, G_A);
      if (k == 7 && op == 0) o = mv(o, D_MDR, L_R, G_A);
      if (k == 7 && op == 2) o.we = 1'b1;
    end
    if (op == 19) begin
      if (k == 3) o = mv(o, D_R, L_CON, G_A);
      if (k == 4) o = mv(o, D_PC, L_Y, -1);
      if (k == 5) begin o = mv(o, D_C, L_Z, -1); o.alu = 5'd3; end
      if (k == 6) o = mv(o, D_ZLO, c ? L_PC : -1, -1);
    end
    if (k == 3) case (op)
      20: o = mv(o, D_R, L_PC, G_A);
      21: o = mv(o, D_PC, L_R, G_B);
      22: o = mv(o, D_INP, L_R, G_A);
      23: o = mv(o, D_R, L_OUTP, G_A);
      24: o = mv(o, D_HI, L_R, G_A);
      25: o = mv(o, D_LO, L_R, G_A);
      default: ;
    endcase
    if (k == 4 && op == 21) o = mv(o, D_R, L_PC, G_A);
    return o;
  endfunction
  // hand-computed literal checks for the directed instructions
  task automatic pins(int op, int k, logic c);
    if (op == 3 && k == 4) begin
      chk("add_T4_alu", bus.alu_op, 5'd3);
      chk("add_T4_gsel", bus.gsel, 3'b001);
      chk("add_T4_drv", bus.drv, 11'h100);
    end
    if (op == 3 && k == 5) begin
      chk("add_T5_drv", bus.drv, 11'h002);
      chk("add_T5_gsel", bus.gsel, 3'b100);
      chk("add_T5_ld", bus.ld, 11'h100);
    end
    if (op == 0 && k == 6) begin
      chk("ld_T6_read", bus.Read, 1'b1);
      chk("ld_T6_ld", bus.ld, 11'h002);
    end
    if (op == 0 && k == 7) begin
      chk("ld_T7_drv", bus.drv, 11'h020);
      chk("ld_T7_ld", bus.ld, 11'h100);
    end
    if (op == 19 && k == 6) chk(c ? "br_taken_ld" : "br_not_taken_ld", bus.ld, c ? 11'h004 : 11'h000);
    if (op == 15 && MD && k == 5) chk("mul_T5_lo", bus.ld, 11'h080);
    if (op == 15 && MD && k == 6) chk("mul_T6_hi", bus.ld, 11'h040);
    if (op == 15 && !MD && k == 3) chk("mul_illegal", bus.illegal, 1'b1);
  endtask
  always @(negedge clk)
    if (exp_v) chk($sformatf("op%0d_k%0d", cur_op, cur_k), dut_out(), exp_o);
  task automatic reset_pulse(string nm);
    #2 clr = 1'b0;
    exp_o = '0;
    cur_op = -1;
    #1 chk(nm, dut_out(), '0);
    @(posedge clk);
    #1 clr = 1'b1;
  endtask
  task automatic run(int op, logic c, int abort_at, int hold);
    for (int k = 0; k < ilen(op); k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin bus.ir_op = 5'(op); bus.con = c; end
      cur_op = op;
      cur_k = k;
      exp_o = model(op, k, c);
      @(negedge clk);
      if (dir) pins(op, k, c);
      if (k == abort_at) begin
        reset_pulse("abort_async");
        return;
      end
    end
    if (op == 27) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1 exp_o = '0;
        cur_k = 100 + i;
      end
      @(negedge clk);
      chk("halt_run", bus.run, 1'b0);
      reset_pulse("halt_clr");
    end
  endtask
  initial begin
    bus.ir_op = '0;
    bus.con = 1'b0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #1 exp_v = 1'b1;
    chk("reset_outputs", dut_out(), '0);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    chk("reset_run_after_release", bus.run, 1'b0);
    run(3, 1'b0, -1, 0);
    run(0, 1'b0, -1, 0);
    run(19, 1'b0, -1, 0);
    run(19, 1'b1, -1, 0);
    run(27, 1'b0, -1, 20);
    run(2, 1'b0, 4, 0);
    run(15, 1'b0, -1, 0);
    run(16, 1'b1, -1, 0);
    run(30, 1'b0, -1, 0);
    dir = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int op;
      int ab;
      op = int'($urandom_range(0, 31));
      ab = $urandom_range(0, 19) == 0 ? int'($urandom_range(0, ilen(op) - 1)) : -1;
      run(op, 1'($urandom_range(0, 1)), ab, int'($urandom_range(1, 5)));
    end
    @(posedge clk);
    #1 exp_o = model(0, 0, 1'b0);
    @(negedge clk);
    #1 exp_v = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
